// File: rtl/morse_sequencer.sv
// Morse code beacon: buffers up to eight letters (J..Q) in a FIFO and keys
// them out on led, one Morse time unit being TICK_DIV clock cycles.
module morse_sequencer #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_letter,
    input  logic       start,
    input  logic       abort,
    output logic       led,
    output logic       busy,
    output logic       done,
    output logic [3:0] count,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MARK,
        S_GAP,
        S_LGAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mem_q [8];
    logic [2:0]    mem_d [8];
    logic [2:0]    wr_ptr_q, wr_ptr_d;
    logic [2:0]    rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    units_q, units_d;
    logic [3:0]    pat_q, pat_d;
    logic [2:0]    left_q, left_d;
    logic          led_q, led_d;
    logic          done_q, done_d;
    logic          tick;
    logic          wr_accept;

    // Returns {length, pattern}; pattern is left-aligned so bit 3 is the
    // symbol on air, 1 = dash.
    function automatic logic [6:0] symbol_lut(input logic [2:0] code);
        case (code)
            3'd0:    symbol_lut = {3'd4, 4'b0111}; // J .---
            3'd1:    symbol_lut = {3'd3, 4'b1010}; // K -.-
            3'd2:    symbol_lut = {3'd4, 4'b0100}; // L .-..
            3'd3:    symbol_lut = {3'd2, 4'b1100}; // M --
            3'd4:    symbol_lut = {3'd2, 4'b1000}; // N -.
            3'd5:    symbol_lut = {3'd3, 4'b1110}; // O ---
            3'd6:    symbol_lut = {3'd4, 4'b0110}; // P .--.
            default: symbol_lut = {3'd4, 4'b1101}; // Q --.-
        endcase
    endfunction

    assign full      = (count_q == 4'd8);
    assign empty     = (count_q == 4'd0);
    assign count     = count_q;
    assign busy      = (state_q != S_IDLE);
    assign led       = led_q;
    assign done      = done_q;
    assign tick      = (presc_q == PRESC_MAX);
    assign wr_accept = (state_q == S_IDLE) && wr_en && !full && !abort;

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        presc_d  = presc_q;
        units_d  = units_q;
        pat_d    = pat_q;
        left_d   = left_q;

        case (state_q)
            S_IDLE: begin
                if (start && (count_q != 4'd0 || wr_accept)) state_d = S_LOAD;
            end
            S_LOAD: begin
                {left_d, pat_d} = symbol_lut(mem_q[rd_ptr_q]);
                rd_ptr_d = rd_ptr_q + 3'd1;
                count_d  = count_q - 4'd1;
                state_d  = S_MARK;
            end
            S_MARK: begin
                // A dot ends on its first tick, a dash on its third.
                if (tick && (!pat_q[3] || units_q == 2'd2)) begin
                    if (left_q > 3'd1) begin
                        state_d = S_GAP;
                        pat_d   = {pat_q[2:0], 1'b0};
                        left_d  = left_q - 3'd1;
                    end else if (count_q != 4'd0) begin
                        state_d = S_LGAP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (tick) state_d = S_MARK;
            end
            S_LGAP: begin
                if (tick && units_q == 2'd2) state_d = S_LOAD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wr_accept) begin
            mem_d[wr_ptr_q] = wr_letter;
            wr_ptr_d        = wr_ptr_q + 3'd1;
            count_d         = count_q + 4'd1;
        end

        if (abort) begin
            state_d  = S_IDLE;
            wr_ptr_d = 3'd0;
            rd_ptr_d = 3'd0;
            count_d  = 4'd0;
        end

        // Unit timing restarts on every state change so each unit is exact.
        if (state_d != state_q || !(state_q == S_MARK || state_q == S_GAP || state_q == S_LGAP)) begin
            presc_d = '0;
            units_d = 2'd0;
        end else if (tick) begin
            presc_d = '0;
            units_d = units_q + 2'd1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        led_d  = (state_d == S_MARK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            presc_q  <= '0;
            units_q  <= 2'd0;
            pat_q    <= 4'd0;
            left_q   <= 3'd0;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            units_q  <= units_d;
            pat_q    <= pat_d;
            left_q   <= left_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000, is the number of CLOCK_50 cycles per Morse time unit (0.5 s at 50 MHz); legal values are 2 and above.
REQ-002 Port CLOCK_50, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, width 1: synchronous, active-high reset.
REQ-004 Port wr_en, input, width 1: append wr_letter to the message buffer.
REQ-005 Port wr_letter, input, width 3: letter code, 0=J 1=K 2=L 3=M 4=N 5=O 6=P 7=Q.
REQ-006 Port start, input, width 1: begin transmitting the buffered message.
REQ-007 Port abort, input, width 1: stop transmission and flush the buffer.
REQ-008 Port led, output, width 1: Morse output, 1 = mark.
REQ-009 Port busy, output, width 1: high in every state except IDLE.
REQ-010 Port done, output, width 1: one-cycle pulse when a message completes normally.
REQ-011 Port count, output, width 4: number of letters buffered, 0 to 8.
REQ-012 Port full, output, width 1: high when count == 8; port empty, output, width 1: high when count == 0.

Function
REQ-013 The message buffer shall be a FIFO of 8 entries x 3 bits with 3-bit read and write pointers that wrap modulo 8.
REQ-014 In IDLE, a write with wr_en=1 and full=0 shall be accepted; writes while full or while busy shall be ignored.
REQ-015 Symbol table, MSB sent first, 1=dash: J .--- ; K -.- ; L .-.. ; M -- ; N -. ; O --- ; P .--. ; Q --.- .
REQ-016 The states shall be IDLE, LOAD, MARK, GAP, LGAP and DONE.
REQ-017 IDLE->LOAD when start=1 and (count>0 or a write is accepted in the same cycle); a letter written in that cycle is included in the message.
REQ-018 start with an empty buffer and no write shall be ignored.
REQ-019 LOAD lasts exactly 1 cycle: pop the FIFO head, latch its pattern and length, clear the prescaler, then go to MARK.
REQ-020 The prescaler shall count 0..TICK_DIV-1 and assert tick when it wraps; it is cleared on entry to MARK, GAP and LGAP, so each unit is exactly TICK_DIV cycles.
REQ-021 Durations: MARK lasts 1 unit for a dot and 3 units for a dash; GAP lasts 1 unit; LGAP lasts 3 units.
REQ-022 At the end of a MARK:
- more symbols remain in the letter -> GAP;
- otherwise, FIFO not empty -> LGAP;
- otherwise -> DONE.
REQ-023 GAP shall go to MARK with the next symbol; LGAP shall go to LOAD.
REQ-024 DONE lasts 1 cycle, asserts done=1, then goes to IDLE.
REQ-025 led shall be registered and equal 1 exactly while in MARK.
REQ-026 A message ends after its last mark; no trailing gap is emitted.
REQ-027 abort=1 in any state shall, on the next edge:
- enter IDLE;
- set led=0;
- empty the FIFO (count=0);
- suppress done.
REQ-028 abort shall take priority over start and wr_en in the same cycle.
REQ-029 start asserted while busy shall be ignored.
REQ-030 count shall decrement on each LOAD pop and increment on each accepted write; the two can never coincide.

Reset
REQ-031 With reset=1 at a clock edge, the block shall enter IDLE and set:
- led=0, busy=0, done=0;
- count=0, empty=1, full=0;
- pointers and prescaler to 0.
REQ-032 reset shall have priority over abort, start and wr_en.
REQ-033 reset asserted mid-transmission shall drop led on the following edge with no done pulse.

Verification (TICK_DIV=4)
REQ-034 Write M, then pulse start at cycle 0 -> LOAD at cycle 1; led=1 for cycles 2-13, 0 for 14-17, 1 for 18-29; done=1 at cycle 30; busy=0 from cycle 31.
REQ-035 Write N then K, then start -> led pattern of 12 on, 4 off, 4 on (N); 12 off (LGAP) plus 1 LOAD cycle; then K as 12,4,4,4,12 alternating on/off; a single done pulse; count goes 2->1->0.
REQ-036 Write 9 letters in IDLE -> count=8 and full=1 after the eighth write; the ninth write is ignored; transmission then emits exactly 8 letters.
REQ-037 start with an empty buffer -> busy stays 0 and led stays 0; start plus wr_en(J) in the same cycle -> J transmitted as 4,4,12,4,12,4,12 cycles on/off alternating.
REQ-038 abort during the second MARK of O -> next cycle led=0, busy=0, count=0; no done pulse; a subsequent start is ignored.
REQ-039 reset during LGAP -> next cycle IDLE with all outputs at reset values; wr_en during busy after restart -> ignored.
